// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART byte receiver with input synchroniser,
// start-bit glitch rejection and framing-error detection.
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 107
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP,
    S_BREAK_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       byte_nxt;
  logic             dv_nxt;
  logic             err_nxt;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      o_RX_Byte   <= 8'h00;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      o_RX_Byte   <= byte_nxt;
      o_RX_DV     <= dv_nxt;
      o_Frame_Err <= err_nxt;
      o_Busy      <= (state_nxt != S_IDLE);
    end
  end

  // Next-state, bit timing and strobe decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    byte_nxt    = o_RX_Byte;
    dv_nxt      = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = 3'd0;
        if (!rx_s) state_nxt = S_START;
      end

      S_START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt   = '0;
          // Line back high at mid start bit: treat as a glitch, silently.
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = 3'd0;
            state_nxt   = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_nxt  = shift;
            dv_nxt    = 1'b1;
            state_nxt = S_CLEANUP;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_BREAK_WAIT;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_CLEANUP: state_nxt = S_IDLE;

      // Hold off until the line returns high so a break cannot re-trigger.
      S_BREAK_WAIT: if (rx_s) state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: one instance at 107 clk/bit and
// one at the 4 clk/bit minimum.
module tb_uart_rx_framer;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx4 = 1'b1;
  logic       dv, ferr, busy;
  logic [7:0] rbyte;
  logic       dv4, ferr4, busy4;
  logic [7:0] rbyte4;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   dv_seen = 0;
  int   err_seen = 0;
  int   dv4_seen = 0;
  exp_t q[$];
  exp_t q4[$];
  exp_t e_mon;
  exp_t e_mon4;

  uart_rx_framer #(.CLKS_PER_BIT(107)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_RX_Serial(rx),
    .o_RX_DV(dv), .o_RX_Byte(rbyte), .o_Frame_Err(ferr), .o_Busy(busy)
  );

  uart_rx_framer #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clk(clk), .i_Reset(rst), .i_RX_Serial(rx4),
    .o_RX_DV(dv4), .o_RX_Byte(rbyte4), .o_Frame_Err(ferr4), .o_Busy(busy4)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Drives the first nbits of a frame (start, 8 data LSB first, stop).
  task automatic send_frame(input bit on4, input logic [7:0] b, input logic stop_b,
                            input bit push, input logic [7:0] exp_b, input int nbits);
    int         cpb;
    logic [9:0] bits;
    cpb  = on4 ? 4 : 107;
    bits = {stop_b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (on4) rx4 = bits[i];
      else     rx  = bits[i];
      if (i == 0 && push) begin
        if (on4) q4.push_back('{!stop_b, exp_b, cyc});
        else     q.push_back('{!stop_b, exp_b, cyc});
      end
      repeat (cpb - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the 107 clk/bit instance.
  always @(negedge clk) begin
    if (!rst && (dv || ferr)) begin
      check("dv_err_exclusive", int'(dv && ferr), 0);
      if (dv)   dv_seen++;
      if (ferr) err_seen++;
      if (q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e_mon = q.pop_front();
        check("strobe_kind_err", int'(ferr), int'(e_mon.is_err));
        check("rx_byte", int'(rbyte), int'(e_mon.b));
        check_rng("strobe_latency", cyc - e_mon.start, 1017, 1023);
      end
    end
  end

  // Monitor for the 4 clk/bit instance.
  always @(negedge clk) begin
    if (!rst && (dv4 || ferr4)) begin
      if (dv4) dv4_seen++;
      if (q4.size() == 0) begin
        check("unexpected_strobe4", 1, 0);
      end else begin
        e_mon4 = q4.pop_front();
        check("strobe_kind_err4", int'(ferr4), int'(e_mon4.is_err));
        check("rx_byte4", int'(rbyte4), int'(e_mon4.b));
        check_rng("strobe_latency4", cyc - e_mon4.start, 39, 43);
      end
    end
  end

  initial begin
    bit saw_busy;
    int busy_low_at;

    idle(3);
    check("reset_dv", int'(dv), 0);
    check("reset_err", int'(ferr), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_byte", int'(rbyte), 8'h00);
    rst = 1'b0;
    idle(20);

    // Single byte.
    send_frame(0, 8'hA5, 1'b1, 1, 8'hA5, 10);
    idle(40);

    // Back-to-back with no idle gap.
    send_frame(0, 8'h00, 1'b1, 1, 8'h00, 10);
    send_frame(0, 8'hFF, 1'b1, 1, 8'hFF, 10);
    idle(40);

    // Start glitch: 20-cycle low pulse.
    saw_busy    = 1'b0;
    busy_low_at = -1;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      else if (saw_busy && busy_low_at < 0) busy_low_at = i;
      if (i == 20) rx = 1'b1;
    end
    check("glitch_busy_seen", int'(saw_busy), 1);
    check_rng("glitch_busy_low_at", busy_low_at, 1, 60);
    idle(20);
    send_frame(0, 8'h5A, 1'b1, 1, 8'h5A, 10);
    idle(40);

    // Framing error followed by a held break.
    send_frame(0, 8'h12, 1'b1, 1, 8'h12, 10);
    idle(40);
    send_frame(0, 8'h3C, 1'b0, 1, 8'h12, 10);
    idle(500);
    check("break_busy_high", int'(busy), 1);
    check("break_byte_held", int'(rbyte), 8'h12);
    rx = 1'b1;
    idle(6);
    check("break_busy_released", int'(busy), 0);
    idle(20);
    send_frame(0, 8'h7E, 1'b1, 1, 8'h7E, 10);
    idle(40);

    // Reset during data bit 4 of 0xC3.
    send_frame(0, 8'hC3, 1'b1, 0, 8'h00, 5);
    rx = 1'b0;
    idle(50);
    rst = 1'b1;
    #1;
    check("midrst_dv", int'(dv), 0);
    check("midrst_err", int'(ferr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_byte", int'(rbyte), 8'h00);
    idle(3);
    rx  = 1'b1;
    rst = 1'b0;
    idle(1200);
    check("midrst_no_restart", int'(busy), 0);
    send_frame(0, 8'h81, 1'b1, 1, 8'h81, 10);
    idle(40);
    check("post_reset_byte", int'(rbyte), 8'h81);

    // Minimum bit period.
    send_frame(1, 8'h96, 1'b1, 1, 8'h96, 10);
    idle(20);

    for (int i = 0; i < 3000 && (q.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    check("scoreboard_drained", q.size() + q4.size(), 0);
    check("dv_total", dv_seen, 7);
    check("err_total", err_seen, 1);
    check("dv4_total", dv4_seen, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
